// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if.sv
//
// Purpose:
//   Bundles for the instruction-memory loader.
//     imem_loader_stream_if : 32-bit word stream from the boot/debug link.
//       master = word source (link), slave = word sink (loader).
//     imem_loader_wr_if     : byte-wide write port of the instruction memory.
//       master = writer (loader), slave = memory.
//
// Signals:
//   imem_loader_stream_if
//     s_valid  word available                     (master -> slave)
//     s_ready  sink can accept a word             (slave  -> master)
//     s_data   32-bit instruction word            (master -> slave)
//     s_last   final word of the program          (master -> slave)
//   imem_loader_wr_if #(ADDR_W)
//     mem_we    byte write enable                 (master -> slave)
//     mem_addr  byte address, ADDR_W bits         (master -> slave)
//     mem_wdata byte data                         (master -> slave)
// ---------------------------------------------------------------------------

interface imem_loader_stream_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface : imem_loader_stream_if

interface imem_loader_wr_if #(
    parameter int ADDR_W = 9
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface : imem_loader_wr_if

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader.sv
//
// Purpose:
//   Writer side of the instruction memory's byte-wide write port. Accepts
//   32-bit instruction words over a valid/ready stream and writes each one as
//   four little-endian bytes: word i lands at byte addresses 4i..4i+3, lowest
//   byte first, one byte per cycle. The pipeline core is held in reset from
//   the moment a load begins until the load finishes, so a program can be
//   placed in instruction memory at run time.
//
// Parameters:
//   ADDR_W     byte-address width of the instruction memory (2^ADDR_W bytes)
//   MAX_WORDS  maximum words per load; 4*MAX_WORDS must not exceed 2^ADDR_W,
//              which keeps the byte address from wrapping inside a load
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle pulse that begins a load (honoured in IDLE / DONE)
//   s           word stream (slave side): s_valid, s_ready, s_data, s_last
//   m           memory write port (master side): mem_we, mem_addr, mem_wdata
//   core_rst    high while the core must be held in reset
//   busy        high while loading (LOAD and WRITE)
//   done        high once a load has finished (DONE)
//   overflow    load ended by reaching MAX_WORDS without s_last
//   word_count  words fully written in the current load
//   checksum    modulo-2^32 sum of accepted words (see macro below)
//
// Build option:
//   LOADER_CHECKSUM_EN  when defined, checksum accumulates every accepted
//                       s_data of the current load (updated in the accept
//                       cycle, cleared on start and on rst). When undefined
//                       the port is tied to zero and no adder exists.
//
// Timing:
//   Every output is a register except s_ready, which is decoded straight
//   from the state (high exactly in LOAD). One word costs five cycles: the
//   accept cycle plus four byte-write cycles.
// ---------------------------------------------------------------------------

module imem_loader #(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = 106
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    imem_loader_stream_if.slave              s,
    imem_loader_wr_if.master                 m,
    output logic                             core_rst,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow,
    output logic [$clog2(MAX_WORDS+1)-1:0]   word_count,
    output logic [31:0]                      checksum
);

    localparam int            CW      = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    state_t            state_q,      state_d;
    logic [31:0]       word_q,       word_d;
    logic              last_q,       last_d;
    logic [1:0]        byte_idx_q,   byte_idx_d;
    logic [CW-1:0]     word_count_q, word_count_d;
    logic              overflow_q,   overflow_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [7:0]        mem_wdata_q,  mem_wdata_d;
    logic              core_rst_q,   core_rst_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    logic          start_load;      // start honoured this cycle
    logic          accept;          // word handshake completes this cycle
    logic [1:0]    byte_idx_next;   // lane that the next write cycle emits
    logic [CW-1:0] word_count_inc;  // word count once this word completes
    logic [7:0]    word_byte [4];   // captured word split into byte lanes

    assign start_load     = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    assign accept         = (state_q == S_LOAD) && s.s_valid;
    assign byte_idx_next  = byte_idx_q + 2'd1;
    assign word_count_inc = word_count_q + CW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_byte[gi] = word_q[8*gi +: 8];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state and registered-output decode
    //
    // Output registers are loaded with the values of the cycle being entered,
    // so in WRITE cycle k the write port already shows byte k. The accept
    // transition therefore preloads byte 0 directly from s_data, and each
    // WRITE cycle k<3 preloads byte k+1 from the captured word.
    // The byte address is simply {word_count, k}, i.e. 4*word_count + k.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        last_d       = last_q;
        byte_idx_d   = byte_idx_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_rst_d   = core_rst_q;
        busy_d       = busy_q;
        done_d       = done_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_load) begin
                    // Re-hold the core in the same update that leaves DONE,
                    // so it is held before the first byte is written.
                    state_d      = S_LOAD;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                    byte_idx_d   = 2'd0;
                    core_rst_d   = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                end
            end

            S_LOAD: begin
                if (accept) begin
                    state_d     = S_WRITE;
                    word_d      = s.s_data;
                    last_d      = s.s_last;
                    byte_idx_d  = 2'd0;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'({word_count_q, 2'd0});
                    mem_wdata_d = s.s_data[7:0];
                end
            end

            S_WRITE: begin
                if (byte_idx_q != 2'd3) begin
                    byte_idx_d  = byte_idx_next;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'({word_count_q, byte_idx_next});
                    mem_wdata_d = word_byte[byte_idx_next];
                end else begin
                    // Last byte of the word is on the port this cycle.
                    word_count_d = word_count_inc;
                    if (last_q) begin
                        state_d    = S_DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else if (word_count_inc == MAX_CNT) begin
                        state_d    = S_DONE;
                        overflow_d = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else begin
                        state_d    = S_LOAD;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register. Reset abandons any partially written word; bytes that
    // already reached memory are left there.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            last_q       <= 1'b0;
            byte_idx_q   <= 2'd0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            last_q       <= last_d;
            byte_idx_q   <= byte_idx_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rst_q   <= core_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Optional running checksum of accepted words
    // -----------------------------------------------------------------------
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_load) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q + s.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'd0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign s.s_ready   = (state_q == S_LOAD);
    assign m.mem_we    = mem_we_q;
    assign m.mem_addr  = mem_addr_q;
    assign m.mem_wdata = mem_wdata_q;
    assign core_rst    = core_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign word_count  = word_count_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader.sv
//
// Bench for imem_loader, built with MAX_WORDS=4 and ADDR_W=4 so that an
// overflowing load fills the whole 16-byte memory. A transaction-level model
// (a queue of pending byte writes plus load-level flags) predicts every
// output each cycle; directed scenarios pin the model with literal values,
// then randomized loads with gaps, stray start pulses and mid-load resets
// follow. Inputs change 1ns after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------

module tb_imem_loader;

    localparam int ADDR_W    = 4;
    localparam int MAX_WORDS = 4;
    localparam int CW        = $clog2(MAX_WORDS + 1);
    localparam int MEM_BYTES = 1 << ADDR_W;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          core_rst, busy, done, overflow;
    logic [CW-1:0] word_count;
    logic [31:0]   checksum;

    imem_loader_stream_if                 st();
    imem_loader_wr_if #(.ADDR_W(ADDR_W))  wr();

    imem_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s          (st),
        .m          (wr),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wlog[$];          // byte writes seen on the DUT port
    int         acc_cyc[$];       // cycles in which a word was accepted
    int         done_cyc = -1;    // cycle in which done last rose
    bit         prev_done = 1'b0;
    logic [7:0] dut_mem [MEM_BYTES];
    logic [7:0] m_mem   [MEM_BYTES];

    // Model of the loader at load/word level
    wr_t         m_q[$];          // byte writes still to come for this word
    bit          m_active   = 1'b0;
    bit          m_finished = 1'b0;
    bit          m_last     = 1'b0;
    bit          m_ovf      = 1'b0;
    int          m_wc       = 0;
    logic [31:0] m_sum      = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Per-cycle compare against the model, then advance the model with the
    // inputs the DUT will sample on the coming rising edge.
    // -----------------------------------------------------------------------
    always @(negedge clk) begin : p_cmp
        logic [31:0] exp_sum;
`ifdef LOADER_CHECKSUM_EN
        exp_sum = m_sum;
`else
        exp_sum = 32'd0;
`endif
        chk("s_ready",    st.s_ready, (m_active && m_q.size() == 0));
        chk("mem_we",     wr.mem_we,  (m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("mem_addr",  wr.mem_addr,  m_q[0].addr);
            chk("mem_wdata", wr.mem_wdata, m_q[0].data);
        end
        chk("busy",       busy,       m_active);
        chk("done",       done,       m_finished);
        chk("core_rst",   core_rst,   !m_finished);
        chk("word_count", word_count, m_wc);
        chk("overflow",   overflow,   m_ovf);
        chk("checksum",   checksum,   exp_sum);

        // DUT-side observation
        if (wr.mem_we === 1'b1) begin
            dut_mem[wr.mem_addr] = wr.mem_wdata;
            wlog.push_back('{int'(wr.mem_addr), wr.mem_wdata});
        end
        if (st.s_valid && st.s_ready) begin
            acc_cyc.push_back(cyc);
            $display("accept cyc=%0d word=%0d data=%08h last=%0b", cyc, m_wc, st.s_data, st.s_last);
        end
        if (done && !prev_done) done_cyc = cyc;
        prev_done = done;

        // Model advance
        if (rst) begin
            m_q.delete();
            m_active   = 1'b0;
            m_finished = 1'b0;
            m_last     = 1'b0;
            m_ovf      = 1'b0;
            m_wc       = 0;
            m_sum      = 32'd0;
        end else if (m_q.size() > 0) begin
            m_mem[m_q[0].addr] = m_q[0].data;
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                m_wc++;
                if (m_last || m_wc == MAX_WORDS) begin
                    m_active   = 1'b0;
                    m_finished = 1'b1;
                    m_ovf      = !m_last;
                end
            end
        end else if (m_active) begin
            if (st.s_valid) begin
                for (int k = 0; k < 4; k++)
                    m_q.push_back('{(4 * m_wc + k) % MEM_BYTES, st.s_data[8*k +: 8]});
                m_sum  = m_sum + st.s_data;
                m_last = st.s_last;
            end
        end else if (start) begin
            m_active   = 1'b1;
            m_finished = 1'b0;
            m_wc       = 0;
            m_ovf      = 1'b0;
            m_sum      = 32'd0;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (all drive 1ns after the rising edge)
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        st.s_valid = 1'b0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Present one word after a random idle gap; returns just after the edge
    // on which it was accepted. Stray start pulses in the gap must be ignored.
    task automatic send_word(input logic [31:0] d, input logic last, input int max_gap);
        int gap;
        bit ok;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            st.s_valid = 1'b0;
            st.s_data  = $urandom;
            st.s_last  = 1'($urandom);
            start      = ($urandom_range(7, 0) == 0);
            tick();
        end
        start      = 1'b0;
        st.s_valid = 1'b1;
        st.s_data  = d;
        st.s_last  = last;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = st.s_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit seen;
        st.s_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = done;
            @(posedge clk);
            #1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        int n_before;
        for (int i = 0; i < MEM_BYTES; i++) begin
            dut_mem[i] = 8'h00;
            m_mem[i]   = 8'h00;
        end
        st.s_valid = 1'b0;
        st.s_data  = 32'd0;
        st.s_last  = 1'b0;

        // Reset values
        repeat (3) tick();
        @(negedge clk);
        chk("rst_core_rst", core_rst,    1);
        chk("rst_busy",     busy,        0);
        chk("rst_done",     done,        0);
        chk("rst_s_ready",  st.s_ready,  0);
        chk("rst_mem_we",   wr.mem_we,   0);
        chk("rst_mem_addr", wr.mem_addr, 0);
        chk("rst_wdata",    wr.mem_wdata, 0);
        chk("rst_wc",       word_count,  0);
        chk("rst_overflow", overflow,    0);
        chk("rst_checksum", checksum,    0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Single word
        wlog.delete();
        pulse_start();
        send_word(32'h00500093, 1'b1, 0);
        wait_done();
        chk("t1_nwrites", wlog.size(), 4);
        if (wlog.size() >= 4) begin
            chk("t1_a0", wlog[0].addr, 0); chk("t1_d0", wlog[0].data, 8'h93);
            chk("t1_a1", wlog[1].addr, 1); chk("t1_d1", wlog[1].data, 8'h00);
            chk("t1_a2", wlog[2].addr, 2); chk("t1_d2", wlog[2].data, 8'h50);
            chk("t1_a3", wlog[3].addr, 3); chk("t1_d3", wlog[3].data, 8'h00);
        end
        @(negedge clk);
        chk("t1_done",     done,       1);
        chk("t1_core_rst", core_rst,   0);
        chk("t1_wc",       word_count, 1);
        chk("t1_overflow", overflow,   0);
        tick();

        // Three back-to-back words, s_valid held high
        wlog.delete();
        acc_cyc.delete();
        pulse_start();
        send_word(32'h00500093, 1'b0, 0);
        send_word(32'h00300113, 1'b0, 0);
        send_word(32'h002081B3, 1'b1, 0);
        wait_done();
        chk("t2_naccept", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk("t2_gap01",      acc_cyc[1] - acc_cyc[0], 5);
            chk("t2_gap12",      acc_cyc[2] - acc_cyc[1], 5);
            chk("t2_accept2done", done_cyc - acc_cyc[0], 15);
        end
        chk("t2_nwrites", wlog.size(), 12);
        if (wlog.size() == 12) begin
            chk("t2_last_addr", wlog[11].addr, 11);
            chk("t2_last_data", wlog[11].data, 8'h00);
        end
        @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
        chk("t2_checksum", checksum, 32'h00A08359);
`else
        chk("t2_checksum", checksum, 32'd0);
`endif
        tick();

        // s_valid toggling: addresses stay contiguous
        wlog.delete();
        pulse_start();
        send_word(32'hA1B2C3D4, 1'b0, 3);
        send_word(32'h0BADF00D, 1'b0, 3);
        send_word(32'h13579BDF, 1'b1, 3);
        wait_done();
        chk("t3_nwrites", wlog.size(), 12);
        foreach (wlog[i]) chk("t3_contig_addr", wlog[i].addr, i);

        // Overflow at MAX_WORDS without s_last
        wlog.delete();
        pulse_start();
        for (int w = 0; w < MAX_WORDS; w++) send_word($urandom, 1'b0, 2);
        wait_done();
        @(negedge clk);
        chk("t4_overflow", overflow,   1);
        chk("t4_wc",       word_count, MAX_WORDS);
        chk("t4_done",     done,       1);
        if (wlog.size() > 0) chk("t4_last_addr", wlog[wlog.size()-1].addr, 15);
        else                 chk("t4_nwrites", wlog.size(), 16);
        tick();
        n_before   = acc_cyc.size();
        st.s_valid = 1'b1;
        st.s_data  = 32'hFEEDFACE;
        st.s_last  = 1'b1;
        repeat (8) tick();
        st.s_valid = 1'b0;
        chk("t4_fifth_not_accepted", acc_cyc.size(), n_before);

        // Reset during byte 2 of word 1
        pulse_start();
        send_word(32'h44332211, 1'b0, 0);
        send_word(32'h88776655, 1'b0, 0);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_pre_addr", wr.mem_addr, 6);
        chk("t5_pre_we",   wr.mem_we,   1);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        st.s_valid = 1'b0;
        @(negedge clk);
        chk("t5_core_rst", core_rst,    1);
        chk("t5_wc",       word_count,  0);
        chk("t5_mem_we",   wr.mem_we,   0);
        chk("t5_busy",     busy,        0);
        chk("t5_mem_addr", wr.mem_addr, 0);
        tick();
        wlog.delete();
        pulse_start();
        send_word(32'hCAFE0123, 1'b1, 1);
        wait_done();
        if (wlog.size() > 0) begin
            chk("t5_restart_addr", wlog[0].addr, 0);
            chk("t5_restart_data", wlog[0].data, 8'h23);
        end else chk("t5_nwrites", wlog.size(), 4);

        // Start in DONE re-holds the core, then reload
        wlog.delete();
        pulse_start();
        @(negedge clk);
        chk("t6_core_rst", core_rst, 1);
        chk("t6_busy",     busy,     1);
        chk("t6_done",     done,     0);
        tick();
        send_word(32'hDEADBEEF, 1'b1, 0);
        wait_done();
        chk("t6_nwrites", wlog.size(), 4);
        if (wlog.size() >= 4) begin
            chk("t6_d0", {wlog[0].addr[7:0], wlog[0].data}, 16'h00EF);
            chk("t6_d1", {wlog[1].addr[7:0], wlog[1].data}, 16'h01BE);
            chk("t6_d2", {wlog[2].addr[7:0], wlog[2].data}, 16'h02AD);
            chk("t6_d3", {wlog[3].addr[7:0], wlog[3].data}, 16'h03DE);
        end

        // Randomized loads
        for (int l = 0; l < 30; l++) begin
            int len;
            bit ovf_run;
            bit aborted;
            aborted = 1'b0;
            ovf_run = ($urandom_range(4, 0) == 0);
            len     = ovf_run ? MAX_WORDS : int'($urandom_range(MAX_WORDS, 1));
            pulse_start();
            for (int w = 0; w < len && !aborted; w++) begin
                send_word($urandom, (!ovf_run && w == len - 1), 3);
                if ($urandom_range(9, 0) == 0) begin
                    repeat ($urandom_range(4, 0)) tick();
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    aborted = 1'b1;
                end
            end
            if (!aborted) wait_done();
            $display("load %0d len=%0d overflow_run=%0b aborted=%0b", l, len, ovf_run, aborted);
            repeat ($urandom_range(2, 0)) tick();
        end

        // Memory image written by the DUT matches the model's
        repeat (6) tick();
        for (int i = 0; i < MEM_BYTES; i++) chk("mem_image", dut_mem[i], m_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_imem_loader
